// File: rtl/mux4way_rr_pkg.sv
// Shared constants and types for the 4-way round-robin fan-in mux.
package mux4way_rr_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned WORD_W = 16;

  typedef logic [SEL_W-1:0] ch_idx_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-requester round-robin arbiter: scans from ptr upward (mod 4),
// first requester wins when enabled.
module rr_arbiter4
  import mux4way_rr_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx
);

  logic            found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = SEL_W'(32'(ptr) + i);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4way_rr.sv
// Merges four valid/ready channels into one registered output channel,
// tagging each word with its source index for a downstream demux.
module mux4way_rr
  import mux4way_rr_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_CH-1:0]         in_valid_i,
  input  logic [NUM_CH*WIDTH-1:0]   in_data_i,
  output logic [NUM_CH-1:0]         in_ready_o,
  output logic                      out_valid_o,
  output logic [WIDTH-1:0]          out_data_o,
  output logic [SEL_W-1:0]          sel_o,
  input  logic                      out_ready_i
);

  logic [WIDTH-1:0]  ch_data [NUM_CH];
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  ch_idx_t           ptr;
  logic              load_en;
  logic              xfer;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = in_data_i[k*WIDTH +: WIDTH];
  end

  // Output register may accept a word when empty or being drained this cycle.
  assign load_en = !out_valid_o || out_ready_i;

  rr_arbiter4 u_arb (
    .req     (in_valid_i),
    .ptr     (ptr),
    .en      (load_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready_o = gnt;
  assign xfer       = |gnt;

  // Priority only rotates on an actual transfer, to one past the winner.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      sel_o       <= '0;
      ptr         <= '0;
    end else if (xfer) begin
      out_valid_o <= 1'b1;
      out_data_o  <= ch_data[gnt_idx];
      sel_o       <= gnt_idx;
      ptr         <= gnt_idx + SEL_W'(1);
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4way_rr.sv
// Self-checking bench for mux4way_rr: directed scenarios plus randomized
// valid/ready traffic against a behavioural model and per-channel scoreboard.
module tb_mux4way_rr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  sel;
  logic        out_ready;

  int tests;
  int errors;

  logic [15:0] d [4];
  logic        pending [4];
  logic [15:0] sb [4][$];

  // Behavioural model of the output register and priority pointer
  logic        m_valid;
  logic [15:0] m_data;
  logic [1:0]  m_sel;
  int          m_ptr;

  mux4way_rr #(.WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .sel_o       (sel),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int grant(input logic [3:0] v, input int p, input logic le);
    if (!le) return -1;
    for (int j = 0; j < 4; j++)
      if (v[(p + j) % 4]) return (p + j) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = '0;
    m_ptr   = 0;
    for (int k = 0; k < 4; k++) begin
      sb[k].delete();
      pending[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: inputs already driven (after a negedge); check grant, update
  // model and scoreboard, then check registered outputs after the edge.
  task automatic cycle(output int g);
    int g_l;
    logic [3:0] exp_rdy;
    in_data = {d[3], d[2], d[1], d[0]};
    #1;
    g_l = grant(in_valid, m_ptr, !m_valid || out_ready);
    exp_rdy = (g_l >= 0) ? 4'(1 << g_l) : 4'b0000;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (m_valid && out_ready) begin
      if (sb[sel].size() == 0) begin
        chk("sb_underflow", 64'(sb[sel].size()), 64'd1);
      end else begin
        chk("sb_word", 64'(out_data), 64'(sb[sel].pop_front()));
      end
    end
    if (g_l >= 0) begin
      sb[g_l].push_back(d[g_l]);
      m_valid = 1'b1;
      m_data  = d[g_l];
      m_sel   = 2'(g_l);
      m_ptr   = (g_l + 1) % 4;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data", 64'(out_data), 64'(m_data));
    chk("sel", 64'(sel), 64'(m_sel));
    @(negedge clk);
    g = g_l;
  endtask

  initial begin
    int g;
    tests  = 0;
    errors = 0;
    in_data = '0;
    for (int k = 0; k < 4; k++) d[k] = '0;
    do_reset();

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      cycle(g);
      chk("idle_rdy", 64'(in_ready), 64'h0);
      chk("idle_valid", 64'(out_valid), 64'h0);
      chk("idle_data", 64'(out_data), 64'h0);
      chk("idle_sel", 64'(sel), 64'h0);
    end

    // Single channel
    in_valid = 4'b0100; d[2] = 16'hA5A5; out_ready = 1'b1;
    in_data = {d[3], d[2], d[1], d[0]};
    #1 chk("single_rdy", 64'(in_ready), 64'h4);
    cycle(g);
    chk("single_valid", 64'(out_valid), 64'h1);
    chk("single_data", 64'(out_data), 64'hA5A5);
    chk("single_sel", 64'(sel), 64'h2);
    in_valid = 4'b0000;
    cycle(g);

    // Round-robin fairness from a fresh pointer
    do_reset();
    d[0] = 16'h0000; d[1] = 16'h1111; d[2] = 16'h2222; d[3] = 16'h3333;
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(g);
      chk("rr_sel", 64'(sel), 64'(i % 4));
      chk("rr_data", 64'(out_data), 64'(16'h1111 * (i % 4)));
      chk("rr_valid", 64'(out_valid), 64'h1);
    end

    // Backpressure holding channel 1's word; ptr now 2
    in_valid = 4'b1001; out_ready = 1'b0;
    d[0] = 16'hC0C0; d[3] = 16'hD3D3;
    for (int i = 0; i < 5; i++) begin
      cycle(g);
      chk("bp_rdy", 64'(in_ready), 64'h0);
      chk("bp_data", 64'(out_data), 64'h1111);
      chk("bp_sel", 64'(sel), 64'h1);
    end
    out_ready = 1'b1;
    in_data = {d[3], d[2], d[1], d[0]};
    #1 chk("bp_release_rdy", 64'(in_ready), 64'h8);
    cycle(g);
    chk("bp_release_sel", 64'(sel), 64'h3);
    chk("bp_release_data", 64'(out_data), 64'hD3D3);

    // Wrap-around: ptr wrapped to 0, so channel 0 beats channel 3
    d[3] = 16'hE3E3;
    cycle(g);
    chk("wrap_first", 64'(sel), 64'h0);
    chk("wrap_first_data", 64'(out_data), 64'hC0C0);
    in_valid = 4'b1000;
    cycle(g);
    chk("wrap_second", 64'(sel), 64'h3);
    chk("wrap_second_data", 64'(out_data), 64'hE3E3);

    // Asynchronous reset mid-stall
    in_valid = 4'b0000; out_ready = 1'b0;
    cycle(g);
    chk("stall_valid", 64'(out_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 64'(out_valid), 64'h0);
    chk("async_rst_data", 64'(out_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(g);

    // Randomized traffic honouring the source hold rule
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (!pending[k] && ($urandom_range(0, 99) < 40)) begin
          pending[k] = 1'b1;
          d[k] = 16'($urandom);
        end
        in_valid[k] = pending[k];
      end
      out_ready = ($urandom_range(0, 99) < 70);
      cycle(g);
      if (g >= 0) pending[g] = 1'b0;
    end

    // Drain: finish pending sources, then empty the output
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 4; k++) in_valid[k] = pending[k];
      out_ready = 1'b1;
      cycle(g);
      if (g >= 0) pending[g] = 1'b0;
    end
    for (int k = 0; k < 4; k++) chk("sb_empty", 64'(sb[k].size()), 64'h0);
    chk("drained_valid", 64'(out_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mux4way_rr.md
Name: mux4way_rr

Overview:
- Fan-in counterpart to the 4-way demultiplexer: merges four valid/ready source channels into one registered output channel.
- A round-robin arbiter picks the source.
- The granted source index is presented on sel_o alongside the data, so a downstream 4-way demux can route responses back to the originating channel.
- Sits on the 16-bit datapath between per-channel producers and a single shared consumer.

Parameters:
- WIDTH, 16: data width of every input and output channel.

Ports:
- clk_i  input  1  system clock; all state changes on rising edge.
- rst_n_i  input  1  asynchronous reset, active-low.
- in_valid_i  input  4  per-channel valid; bit k belongs to channel k.
- in_data_i  input  4*WIDTH  channel k data in bits [k*WIDTH +: WIDTH].
- in_ready_o  output  4  per-channel ready; one-hot or zero (combinational grant).
- out_valid_o  output  1  registered output valid.
- out_data_o  output  WIDTH  registered output data.
- sel_o  output  2  index of the channel whose word is in the output register.
- out_ready_i  input  1  downstream ready.

Behaviour:
- Reset, asynchronous, on rst_n_i low:
  - out_valid_o=0, out_data_o=0, sel_o=2'b00.
  - Round-robin pointer ptr=0, giving priority order 0,1,2,3.
  - Reset mid-transfer discards the held word; no partial state survives.
- load_en = !out_valid_o || out_ready_i. The output register may load when empty or when its current word is being consumed this cycle.
- Grant, combinational:
  - Scan channels ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first with in_valid_i set wins, if load_en=1.
  - in_ready_o has only the winner's bit set; all zero if load_en=0 or no valid.
- Transfer on channel k = in_valid_i[k] && in_ready_o[k]. On that edge:
  - out_data_o <= channel k data.
  - sel_o <= k.
  - out_valid_o <= 1.
  - ptr <= k+1 mod 4 (3 wraps to 0).
- Output consumed (out_valid_o && out_ready_i) with no new grant: out_valid_o <= 0. out_data_o and sel_o hold their last values.
- Simultaneous consume and grant: the new word is loaded, out_valid_o stays 1. This gives full throughput of one word per cycle, with no bubble.
- Stall (out_valid_o=1, out_ready_i=0): all in_ready_o=0. Output data, sel_o and ptr are stable.
- Latency: one cycle from input transfer to out_valid_o.
- ptr changes only on a transfer; idle cycles do not rotate priority.
- Sources must hold valid/data until ready. No combinational path from in_valid_i to out_valid_o. in_ready_o depends combinationally on in_valid_i, out_valid_o and out_ready_i.
- No data loss or duplication under any valid/ready pattern.

Decomposition:
- Shared package:
  - NUM_CH=4, SEL_W=2, WORD_W=16.
  - Typedef for the 2-bit channel index.
- Sub-module rr_arbiter4:
  - Inputs: req[3:0], ptr[1:0], en.
  - Outputs: one-hot gnt[3:0], gnt_idx[1:0].
  - Purely combinational; reused later by other fan-in blocks.
- Top holds ptr, the output register and the data mux.

Test Plan:
- Reset then idle: after rst_n_i released with all in_valid_i=0, verify in_ready_o=0000, out_valid_o=0, out_data_o=0, sel_o=00 for 10 cycles. Assert rst_n_i asynchronously mid-stall and verify out_valid_o drops immediately.
- Single channel: in_valid_i=0100, channel 2 data=16'hA5A5, out_ready_i=1. Verify in_ready_o=0100, then next cycle out_valid_o=1, out_data_o=A5A5, sel_o=10.
- Round-robin fairness: all four valid continuously with data 16'h0000/1111/2222/3333, out_ready_i=1. Verify sel_o sequence 0,1,2,3,0,1 with matching data and out_valid_o held at 1 every cycle.
- Backpressure: output holding channel 1's word, out_ready_i=0 for 5 cycles with channels 0 and 3 valid. Verify in_ready_o=0000 and out_data_o/sel_o stable. On release, channel 3 is granted next (ptr=2 scans 2,3,0,1).
- Wrap-around: the only grant is channel 3. Then channels 0 and 3 both valid: verify channel 0 wins (ptr wrapped to 0), then channel 3.
- Randomized valid/ready, 2000 cycles: scoreboard per channel. Check every input word appears exactly once, in per-channel order, with the correct sel_o.
